// File: rtl/regfile_dump_if.sv
// Word stream from the register-file dumper to a debug formatter (UART/LCD).
// Each word carries its register address; out_last marks the end of a dump.
interface regfile_dump_if;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump.sv
// Sweeps a range of register-file debug addresses and streams {addr, value} words out.
// Define REGDUMP_CKSUM_EN to append a 32-bit sum word (addr 0, last=1) after the registers.
module regfile_dump (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [4:0]            first_addr,
    input  logic [4:0]            last_addr,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            test_addr,
    input  logic [31:0]           test_data,
    regfile_dump_if.master        dump
);

`ifdef REGDUMP_CKSUM_EN
    typedef enum logic [2:0] {StIdle, StFetch, StSend, StCksum, StDone} state_e;
`else
    typedef enum logic [2:0] {StIdle, StFetch, StSend, StDone} state_e;
`endif

    state_e      state_q;
    logic        busy_q;
    logic        done_q;
    logic [4:0]  test_addr_q;
    logic [4:0]  last_q;
    logic        valid_q;
    logic [4:0]  addr_q;
    logic [31:0] data_q;
    logic        last_word_q;
`ifdef REGDUMP_CKSUM_EN
    logic [31:0] acc_q;
`endif

    logic hs;
    assign hs = valid_q && dump.out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            test_addr_q <= 5'd0;
            last_q      <= 5'd0;
            valid_q     <= 1'b0;
            addr_q      <= 5'd0;
            data_q      <= 32'd0;
            last_word_q <= 1'b0;
`ifdef REGDUMP_CKSUM_EN
            acc_q       <= 32'd0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        last_q      <= last_addr;
                        test_addr_q <= first_addr;
                        busy_q      <= 1'b1;
`ifdef REGDUMP_CKSUM_EN
                        acc_q       <= 32'd0;
`endif
                        state_q     <= StFetch;
                    end
                end
                StFetch: begin
                    // test_addr has been stable a full cycle, so the async read is settled.
                    data_q  <= test_data;
                    addr_q  <= test_addr_q;
`ifdef REGDUMP_CKSUM_EN
                    last_word_q <= 1'b0;
`else
                    last_word_q <= (test_addr_q == last_q);
`endif
                    valid_q <= 1'b1;
                    state_q <= StSend;
                end
                StSend: begin
                    if (hs) begin
`ifdef REGDUMP_CKSUM_EN
                        acc_q <= acc_q + data_q;
`endif
                        if (addr_q == last_q) begin
`ifdef REGDUMP_CKSUM_EN
                            // valid stays up; the sum word follows without a gap
                            addr_q      <= 5'd0;
                            data_q      <= acc_q + data_q;
                            last_word_q <= 1'b1;
                            state_q     <= StCksum;
`else
                            valid_q     <= 1'b0;
                            last_word_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= StDone;
`endif
                        end else begin
                            valid_q     <= 1'b0;
                            test_addr_q <= test_addr_q + 5'd1;
                            state_q     <= StFetch;
                        end
                    end
                end
`ifdef REGDUMP_CKSUM_EN
                StCksum: begin
                    if (hs) begin
                        valid_q     <= 1'b0;
                        last_word_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= StDone;
                    end
                end
`endif
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign test_addr      = test_addr_q;
    assign dump.out_valid = valid_q;
    assign dump.out_addr  = addr_q;
    assign dump.out_data  = data_q;
    assign dump.out_last  = last_word_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: expected words are queued at start, popped on handshake.
// Works with or without REGDUMP_CKSUM_EN.
module tb_regfile_dump;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic        busy;
    logic        done;
    logic [4:0]  test_addr;
    logic [31:0] test_data;
    logic [31:0] rf [32];

    regfile_dump_if dif ();

    regfile_dump u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .busy       (busy),
        .done       (done),
        .test_addr  (test_addr),
        .test_data  (test_data),
        .dump       (dif.master)
    );

    // Register file model: r0 always reads zero.
    assign test_data = (test_addr == 5'd0) ? 32'd0 : rf[test_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } word_t;

    word_t sb[$];
    word_t held;
    bit    stall;
    int    n_vec;
    int    n_err;
    int    done_cnt;
    int    ready_mode;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : rf[a];
    endfunction

    // out_ready driver: 0 = tied high, 1 = random ~30% duty
    initial begin
        dif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) dif.out_ready = ($urandom_range(0, 99) < 30);
            else                 dif.out_ready = 1'b1;
        end
    end

    // Output monitor: hold-stability and scoreboard compare on each handshake.
    always @(negedge clk) begin
        if (!resetn) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", dif.out_valid, 1);
                if (dif.out_valid) begin
                    check("hold_addr", dif.out_addr, held.a);
                    check("hold_data", dif.out_data, held.d);
                    check("hold_last", dif.out_last, held.l);
                end
            end
            if (dif.out_valid && dif.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", sb.size(), 1);
                end else begin
                    word_t e;
                    e = sb.pop_front();
                    check("word_addr", dif.out_addr, e.a);
                    check("word_data", dif.out_data, e.d);
                    check("word_last", dif.out_last, e.l);
                end
            end
            stall  = dif.out_valid && !dif.out_ready;
            held.a = dif.out_addr;
            held.d = dif.out_data;
            held.l = dif.out_last;
            if (done) done_cnt++;
        end
    end

    function automatic int exp_words(input logic [4:0] fa, input logic [4:0] la);
        logic [4:0] span;
        span = la - fa;
        return int'(span) + 1;
    endfunction

    task automatic push_expected(input logic [4:0] fa, input logic [4:0] la, input int n_push);
        int          n;
        logic [31:0] sum;
        logic [4:0]  a;
        word_t       w;
        n   = exp_words(fa, la);
        sum = 32'd0;
        for (int i = 0; i < n && i < n_push; i++) begin
            a   = fa + 5'(i);
            w.a = a;
            w.d = exp_data(a);
            sum = sum + w.d;
`ifdef REGDUMP_CKSUM_EN
            w.l = 1'b0;
`else
            w.l = (i == n - 1);
`endif
            sb.push_back(w);
        end
`ifdef REGDUMP_CKSUM_EN
        if (n_push >= n) begin
            w.a = 5'd0;
            w.d = sum;
            w.l = 1'b1;
            sb.push_back(w);
        end
`endif
    endtask

    task automatic accept_start(input logic [4:0] fa, input logic [4:0] la);
        @(negedge clk);
        first_addr = fa;
        last_addr  = la;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_dump(input logic [4:0] fa, input logic [4:0] la, input bit noise);
        int n;
        int cycles;
        int d0;
        int exp_cycles;
        n = exp_words(fa, la);
`ifdef REGDUMP_CKSUM_EN
        exp_cycles = 2 * n + 1;
`else
        exp_cycles = 2 * n;
`endif
        push_expected(fa, la, 64);
        d0         = done_cnt;
        ready_mode = noise ? 1 : 0;
        accept_start(fa, la);
        cycles = 0;
        while (!done && cycles < 4000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (cycles == 1) check("first_valid", dif.out_valid, 1);
            // spurious starts while busy must be ignored
            if (noise && !done) start = ($urandom_range(0, 3) == 0);
            else                start = 1'b0;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        if (!noise) check("latency", cycles, exp_cycles);
        check("busy_at_done", busy, 1);
        check("sb_drained", sb.size(), 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("valid_idle", dif.out_valid, 0);
        check("done_count", done_cnt - d0, 1);
        repeat (3) @(negedge clk);
        check("no_restart", busy, 0);
        ready_mode = 0;
    endtask

    initial begin
        int d0;
        n_vec      = 0;
        n_err      = 0;
        done_cnt   = 0;
        ready_mode = 0;
        stall      = 1'b0;
        start      = 1'b0;
        first_addr = 5'd0;
        last_addr  = 5'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        resetn = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", dif.out_valid, 0);
        check("rst_last", dif.out_last, 0);
        check("rst_test_addr", test_addr, 0);
        check("rst_out_addr", dif.out_addr, 0);
        check("rst_out_data", dif.out_data, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        rf[5] = 32'h1234_5678;
        run_dump(5'd5, 5'd5, 1'b0);

        for (int i = 1; i < 32; i++) rf[i] = i * 32'h0101_0101;
        run_dump(5'd0, 5'd31, 1'b0);
        run_dump(5'd30, 5'd1, 1'b0);

        run_dump(5'd3, 5'd12, 1'b1);
        run_dump(5'd20, 5'd4, 1'b1);

        // Reset while word 3 is being presented
        ready_mode = 0;
        push_expected(5'd4, 5'd20, 3);
        d0 = done_cnt;
        accept_start(5'd4, 5'd20);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mid_valid", dif.out_valid, 1);
        check("mid_addr", dif.out_addr, 6);
        #2;
        resetn = 1'b0;
        #1;
        check("abort_valid", dif.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sb", sb.size(), 0);
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        resetn = 1'b1;
        run_dump(5'd4, 5'd7, 1'b0);

        rf[1] = 32'hFFFF_FFFF;
        rf[2] = 32'd2;
        rf[3] = 32'd3;
        run_dump(5'd1, 5'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug-side reader for the register file's debug read port (test_addr/test_data).
- On a start request it sweeps a programmable range of register addresses and samples each value.
- Each sampled value is streamed out, tagged with its register address, over a valid/ready interface for a debug UART/LCD formatter.
- Operates on the debug port only; never touches the CPU read/write ports.

Parameters:
- none

Ports:
clk  input  1  system clock; all state changes on rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  request a dump; sampled only in IDLE
first_addr  input  5  first register of the sweep; latched on accepted start
last_addr  input  5  last register of the sweep, inclusive; latched on accepted start
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse after the final word's handshake
test_addr  output  5  drives the register file debug address (registered)
test_data  input  32  combinational debug read data from the register file
out_valid  output  1  output word valid
out_ready  input  1  consumer ready
out_addr  output  5  register address of the current word
out_data  output  32  register value of the current word
out_last  output  1  high with the final word of the dump

Behaviour:
- Reset, asynchronous, effective immediately:
  - state=IDLE.
  - busy, done, out_valid and out_last = 0.
  - test_addr, out_addr and out_data = 0.
  - Checksum accumulator = 0.
  - Latched range = 0.
- Reset mid-dump aborts silently: no done, out_valid drops at once.
- States: IDLE, FETCH, SEND, CKSUM (only with the optional feature), DONE.
- IDLE:
  - start=1 latches first_addr/last_addr, loads test_addr=first_addr, clears the accumulator, goes to FETCH.
  - start=0 holds in IDLE.
  - start while busy is ignored and not queued.
- FETCH (exactly one cycle):
  - test_addr is stable, so test_data is valid (asynchronous read).
  - Register out_data<=test_data and out_addr<=test_addr.
  - Set out_last=1 if test_addr==last_addr (and the feature is off).
  - Go to SEND.
- SEND:
  - out_valid=1. out_addr, out_data and out_last are held stable until out_valid&&out_ready.
  - out_valid never drops without a handshake.
  - On handshake, add out_data to the accumulator (mod 2^32).
  - If out_addr==last_addr: go to CKSUM if the feature is on, else DONE.
  - Otherwise test_addr<=test_addr+1 (5-bit wrap, 31->0) and go to FETCH.
- DONE (one cycle): done=1, out_valid=0, out_last=0, then IDLE.
- Timing:
  - Start accepted at edge N: first out_valid at cycle N+2.
  - Minimum 2 cycles per word with out_ready tied high.
- Sweep range:
  - Words emitted = ((last_addr - first_addr) mod 32) + 1.
  - first_addr==last_addr gives 1 word.
  - first_addr > last_addr wraps through 31->0. Example: 30..1 gives 30,31,0,1.
  - first=0,last=31 gives all 32.
- Register 0 is read via the port like any other (the register file returns 0).
- Register writes during a sweep:
  - A register is sampled in its FETCH cycle.
  - A write landing on the same edge as that FETCH sample is not seen, since the old value is captured.
- busy is high from the cycle after start acceptance through DONE inclusive.

Optional Feature:
- REGDUMP_CKSUM_EN defined:
  - After the last register word, enter CKSUM.
  - CKSUM presents out_valid=1, out_addr=5'd0, out_data=accumulated 32-bit sum of all sent words, out_last=1.
  - Hold until handshake, then DONE.
  - Register words never assert out_last.
- REGDUMP_CKSUM_EN undefined:
  - CKSUM state and accumulator are absent.
  - out_last is asserted on the last register word.
  - Word count is exactly the range size.

Test Plan:
- Reset then preload rf[5]=0x1234_5678. Pulse start with first=5,last=5, out_ready=1 -> one word {addr 5, 0x12345678, last=1} at N+2, done pulse one cycle after the handshake, busy low afterwards.
- Preload rf[i]=i*0x01010101. Full sweep first=0,last=31, out_ready=1 -> 32 words with addr 0..31 and matching data, 64 cycles start-to-done-1, last only on addr 31.
- Wrap sweep first=30,last=1 -> addresses 30,31,0,1 in order, data 0x1E1E1E1E,0x1F1F1F1F,0,0x01010101.
- Backpressure: out_ready random 30% duty, plus extra start pulses while busy -> out_addr/out_data/out_last stable while valid&&!ready, no word lost or duplicated, extra starts ignored.
- Reset mid-dump: assert resetn=0 while in SEND on word 3 -> out_valid and busy 0 immediately, no done. A new start after release dumps from first_addr again.
- With REGDUMP_CKSUM_EN, sweep 1..3 with values 0xFFFFFFFF,2,3 -> 4 words, final {addr 0, data 0x00000004, last=1}.
